portout_ser: RTL
================

Name: portout_ser

Overview:
- Output-side stage of the 8-port serial router. One instance per output port.
- Consumes 32-bit payload words from the per-port output queue through a rdy/pop handshake.
- Serializes each word onto the port pins dout/valido_n/frameo_n, using the same framing protocol that portin decodes on the input side.
- Holds one word in a holding register so it can accept the next word while the current one is still shifting out.

Parameters:
WIDTH, 32, payload bits per frame (>=2)
GAP_CYCLES, 1, idle cycles (frameo_n=1, valido_n=1) inserted between consecutive frames (0..15)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
payload  input  WIDTH  word from the output queue, show-ahead; valid while rdy=1
rdy  input  1  queue non-empty; payload is valid
pop  output  1  word accepted this cycle; queue advances at this rising edge
dout  output  1  serial data, LSB first
valido_n  output  1  active-low: dout carries a valid bit
frameo_n  output  1  active-low frame marker; high on the last bit of a frame
busy  output  1  frame in progress or holding register full

Behaviour:
- Reset (sampled at a clock edge while reset=1):
  - dout=0, valido_n=1, frameo_n=1, busy=0.
  - Holding register empty, bit counter 0, state IDLE.
  - pop is forced to 0 while reset=1.
- pop is combinational: pop = rdy & ~reset & (~hold_full | load). "load" is high in a cycle where the holding register moves into the shift register.
  - On a pop cycle, payload is captured into the holding register at that edge.
  - A load and a pop in the same cycle give a simultaneous refill.
- States:
  - IDLE: outputs idle. If hold_full, assert load and go to SHIFT.
  - SHIFT: one bit per cycle, WIDTH cycles.
    - At the end of the last bit, go to GAP if GAP_CYCLES>0.
    - Otherwise, if hold_full, assert load and stay in SHIFT (back-to-back frames).
    - Otherwise go to IDLE.
  - GAP: count GAP_CYCLES idle cycles, then behave as IDLE (load if hold_full, else go to IDLE).
- Outputs are registered (driven from flops). During the cycle with bit index k:
  - dout = payload[k], valido_n = 0.
  - frameo_n = 0 for k = 0..WIDTH-2 and frameo_n = 1 for k = WIDTH-1.
- Outside SHIFT: valido_n=1, frameo_n=1, dout=0.
- Latency: if pop is high in cycle c, bit0 is on the pins in cycle c+2 (hold -> load edge -> output flop), provided the serializer is idle.
- Throughput: one frame per WIDTH+GAP_CYCLES cycles. With rdy held high, the holding register refills on each load and no extra bubbles appear.
- Bit counter: width $clog2(WIDTH). It resets to 0 on load and does not wrap within a frame.
- busy = (state!=IDLE) | hold_full.
- rdy=0: no pop. Serialization of a word already held still completes.
- rdy=1 with hold_full and no load: pop=0 and payload is ignored. The queue must hold the word stable.
- Reset mid-frame: on the next edge, outputs return to idle values. The frame is truncated (frameo_n never shows a last-bit high with valido_n=0). The held word is discarded.
- payload changing while rdy=0 has no effect.

Decomposition:
- Shared package router_pkg:
  - PAYLOAD_W=32, ADDR_W=4, NUM_PORTS=8.
  - State enum type portout_state_t {IDLE, SHIFT, GAP}.
  - Idle pin constants (FRAME_IDLE=1, VALID_IDLE=1).
- No sub-module needed. The block is a single module: holding register, shift register, bit counter, gap counter, FSM.
- The router top instantiates it in a generate loop over NUM_PORTS.

Test Plan:
- Single word: payload=32'hA5A5_0001 with rdy high for 1 cycle.
  - pop pulses once.
  - 2 cycles later dout shows bits 1,0,0,0,... LSB first over 32 cycles, with valido_n=0 throughout.
  - frameo_n=0 for 31 cycles and =1 on the 32nd; busy falls after the frame.
- Back-to-back, GAP_CYCLES=1: words 32'h0000_0003 then 32'h8000_0000, rdy held high.
  - Second pop occurs on the first frame's load cycle.
  - Exactly 1 idle cycle separates the frames.
  - The second frame's last bit is dout=1 with frameo_n=1.
- GAP_CYCLES=0, three words 32'hFFFF_FFFF: 96 consecutive cycles with valido_n=0, with frameo_n high exactly at cycles 31, 63 and 95.
- Hold full stall: rdy high continuously. Check that pop is 0 for every cycle except load cycles and the initial empty-hold cycle, with no word lost or duplicated. Scoreboard 10 random words against the deserialized output.
- Reset at bit 10 of frame 32'h1234_5678:
  - Next cycle: valido_n=1, frameo_n=1, dout=0, busy=0.
  - The held word is dropped.
  - The next pop after reset is serialized correctly.
- rdy toggling with a random payload while hold_full: payload changes while pop=0 do not corrupt the held word.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants and output-port state type
package router_pkg;

  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = 4;
  localparam int NUM_PORTS = 8;

  // Idle levels of the active-low port pins
  localparam logic FRAME_IDLE = 1'b1;
  localparam logic VALID_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } portout_state_t;

endpackage

// File: rtl/portout_ser.sv
// rtl/portout_ser.sv - output-port serializer: holding register, shifter, framing FSM
module portout_ser
  import router_pkg::*;
#(
  parameter int WIDTH      = PAYLOAD_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] payload,
  input  logic             rdy,
  output logic             pop,
  output logic             dout,
  output logic             valido_n,
  output logic             frameo_n,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  portout_state_t   state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             dout_q, dout_d;
  logic             valido_n_q, valido_n_d;
  logic             frameo_n_q, frameo_n_d;
  logic             load;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    load        = 1'b0;
    // Pins fall back to idle unless a bit is scheduled for the next cycle
    dout_d      = 1'b0;
    valido_n_d  = VALID_IDLE;
    frameo_n_d  = FRAME_IDLE;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = 4'd0;
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d      = cnt_q + CW'(1);
          shreg_d    = {1'b0, shreg_q[WIDTH-1:1]};
          dout_d     = shreg_q[0];
          valido_n_d = 1'b0;
          frameo_n_d = ((cnt_q + CW'(1)) == LAST_BIT);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit 0 goes straight to the output flop; the shifter keeps the rest
    if (load) begin
      state_d     = SHIFT;
      shreg_d     = {1'b0, hold_q[WIDTH-1:1]};
      cnt_d       = '0;
      dout_d      = hold_q[0];
      valido_n_d  = 1'b0;
      frameo_n_d  = 1'b0;
      hold_full_d = 1'b0;
    end

    pop = rdy & ~reset & (~hold_full_q | load);
    if (pop) begin
      hold_d      = payload;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= 4'd0;
      dout_q      <= 1'b0;
      valido_n_q  <= VALID_IDLE;
      frameo_n_q  <= FRAME_IDLE;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      dout_q      <= dout_d;
      valido_n_q  <= valido_n_d;
      frameo_n_q  <= frameo_n_d;
    end
  end

  assign dout     = dout_q;
  assign valido_n = valido_n_q;
  assign frameo_n = frameo_n_q;
  assign busy     = (state_q != IDLE) | hold_full_q;

endmodule
